sn_generate: RTL and testbench

Stochastic-number generator: converts a binary value written over the 32-bit register interface into a stochastic bitstream on SN_OUT_P / SN_OUT_N, one bit per enabled cycle. It is the encoder counterpart of the ones-counter on the decode side; the two share the same three number formats, so a generator/counter pair configured with the same MODE and WIDTH round-trips a value. It sits between the processor-side register bank and the stochastic compute fabric.

---
 rtl/sn_pkg.sv | 19 +
 rtl/sn_generate_if.sv | 23 ++
 rtl/sn_lfsr.sv | 25 ++
 rtl/sn_generate.sv | 140 ++++++++++++++
 tb/tb_sn_generate.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sn_pkg.sv
// Shared definitions for the stochastic-number generator and its ones-counter:
// number formats, LFSR polynomial mask and the power-on seed.
package sn_pkg;

  typedef enum logic [1:0] {
    SN_UNIPOLAR = 2'd0,
    SN_BIPOLAR  = 2'd1,
    SN_TWOLINE  = 2'd2
  } sn_mode_e;

  localparam logic [31:0] SN_LFSR_MASK    = 32'h8020_0003;
  localparam logic [31:0] SN_DEFAULT_SEED = 32'h1234_5678;

  // Right-shifting Galois step for x^32+x^22+x^2+x+1
  function automatic logic [31:0] sn_lfsr_step(input logic [31:0] state);
    return {1'b0, state[31:1]} ^ (state[0] ? SN_LFSR_MASK : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/sn_generate_if.sv
// Register-side bus of the stochastic-number generator: write strobes, write
// data, stream outputs and value readback.
interface sn_generate_if;
  logic        EN;
  logic [31:0] DATA_IN;
  logic        DATA_WE;
  logic        SEED_WE;
  logic        LEN_WE;
  logic        SN_OUT_P;
  logic        SN_OUT_N;
  logic [31:0] DATA_OUT;
  logic        DONE;

  modport master (
    output EN, DATA_IN, DATA_WE, SEED_WE, LEN_WE,
    input  SN_OUT_P, SN_OUT_N, DATA_OUT, DONE
  );

  modport slave (
    input  EN, DATA_IN, DATA_WE, SEED_WE, LEN_WE,
    output SN_OUT_P, SN_OUT_N, DATA_OUT, DONE
  );
endinterface

// File: rtl/sn_lfsr.sv
// 32-bit Galois LFSR random source with seed load and advance enable.
// A zero seed would lock the register, so it is replaced by 1.
module sn_lfsr
  import sn_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] state
);

  // Load has priority over advance so a seed write always lands intact
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state <= SN_DEFAULT_SEED;
    end else if (load) begin
      state <= (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;
    end else if (advance) begin
      state <= sn_lfsr_step(state);
    end
  end

endmodule

// File: rtl/sn_generate.sv
// Stochastic-number generator: compares LFSR samples against a saturated value
// register to emit one stream bit per EN cycle. Optional SN_LENGTH_EN adds a length counter.
module sn_generate
  import sn_pkg::*;
#(
  parameter logic [1:0] MODE  = 2'd0,
  parameter int         WIDTH = 16
) (
  input logic          CLK,
  input logic          RST_X,
  sn_generate_if.slave bus
);

  localparam int                     VW      = WIDTH + 2;
  localparam logic signed [32:0]     LIMIT   = 33'sd1 <<< WIDTH;
  localparam logic signed [VW-1:0]   LIMIT_V = VW'(LIMIT);
  localparam logic [VW-1:0]          OFFSET  = VW'(LIMIT);
  localparam bit                     IS_UNI  = (MODE == SN_UNIPOLAR);
  localparam bit                     IS_BIP  = (MODE == SN_BIPOLAR);

  logic signed [VW-1:0] val;
  logic signed [VW-1:0] sat;
  logic signed [31:0]   val_ext;
  logic signed [32:0]   din_u;
  logic signed [32:0]   din_s;
  logic [31:0]          lfsr_state;
  logic [WIDTH:0]       r;
  logic [VW-1:0]        bip_thresh;
  logic signed [VW-1:0] neg_val;
  logic [WIDTH:0]       mag;
  logic                 uni_hit;
  logic                 bip_hit;
  logic                 two_hit;
  logic                 p_next;
  logic                 n_next;
  logic                 p_q;
  logic                 n_q;
  logic                 active;
  logic                 unused_state_hi;

  assign din_u = {1'b0, bus.DATA_IN};
  assign din_s = {bus.DATA_IN[31], bus.DATA_IN};

  // Unipolar treats the write as unsigned; the signed formats clamp symmetrically
  always_comb begin
    sat = '0;
    if (IS_UNI) begin
      sat = (din_u > LIMIT) ? LIMIT_V : din_u[VW-1:0];
    end else if (din_s > LIMIT) begin
      sat = LIMIT_V;
    end else if (din_s < -LIMIT) begin
      sat = -LIMIT_V;
    end else begin
      sat = din_s[VW-1:0];
    end
  end

  assign r               = lfsr_state[WIDTH:0];
  assign unused_state_hi = ^lfsr_state[31:WIDTH+1];
  assign bip_thresh      = val + OFFSET;
  assign neg_val         = -val;
  assign mag             = val[VW-1] ? neg_val[WIDTH:0] : val[WIDTH:0];

  assign uni_hit = {1'b0, r[WIDTH-1:0]} < val[WIDTH:0];
  assign bip_hit = {1'b0, r} < bip_thresh;
  assign two_hit = {1'b0, r[WIDTH-1:0]} < mag;

  always_comb begin
    p_next = 1'b0;
    n_next = 1'b0;
    if (IS_UNI) begin
      p_next = uni_hit;
    end else if (IS_BIP) begin
      p_next = bip_hit;
    end else begin
      p_next = two_hit & ~val[VW-1];
      n_next = two_hit &  val[VW-1];
    end
  end

`ifdef SN_LENGTH_EN
  logic [31:0] rem;
  logic        done_q;

  assign active   = bus.EN && (rem != 32'd0);
  assign bus.DONE = done_q;

  // A length write wins over the decrement of the same cycle
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rem    <= 32'd0;
      done_q <= 1'b1;
    end else if (bus.LEN_WE) begin
      rem    <= bus.DATA_IN;
      done_q <= (bus.DATA_IN == 32'd0);
    end else if (active) begin
      rem    <= rem - 32'd1;
      done_q <= (rem == 32'd1);
    end
  end
`else
  logic unused_len_we;

  assign active        = bus.EN;
  assign bus.DONE      = 1'b0;
  assign unused_len_we = bus.LEN_WE;
`endif

  // Emitted bit always uses the pre-edge value and LFSR state
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      val <= '0;
      p_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      if (bus.DATA_WE) begin
        val <= sat;
      end
      if (bus.EN) begin
        p_q <= active & p_next;
        n_q <= active & n_next;
      end
    end
  end

  assign val_ext      = val;
  assign bus.DATA_OUT = val_ext;
  assign bus.SN_OUT_P = p_q;
  assign bus.SN_OUT_N = n_q;

  sn_lfsr u_lfsr (
    .CLK     (CLK),
    .RST_X   (RST_X),
    .load    (bus.SEED_WE),
    .seed    (bus.DATA_IN),
    .advance (active),
    .state   (lfsr_state)
  );

endmodule

// File: tb/tb_sn_generate.sv
// Directed bench for sn_generate: unipolar, bipolar and two-line instances at
// WIDTH=16 driven in lockstep and compared against a behavioural model.
module tb_sn_generate;

  localparam int W = 16;

  logic        CLK = 1'b0;
  logic        RST_X;
  logic        en;
  logic        data_we;
  logic        seed_we;
  logic        len_we;
  logic [31:0] data_in;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_state;
  longint      m_val_u;
  longint      m_val_s;
  longint      m_rem;
  logic        m_p_u, m_p_b, m_p_t, m_n_t, m_done;
  logic [31:0] cnt_u, cnt_b, cnt_tp, cnt_tn, m_cnt_tn;

  always #5 CLK = ~CLK;

  sn_generate_if bus_u ();
  sn_generate_if bus_b ();
  sn_generate_if bus_t ();

  assign bus_u.EN = en;       assign bus_b.EN = en;       assign bus_t.EN = en;
  assign bus_u.DATA_IN = data_in; assign bus_b.DATA_IN = data_in; assign bus_t.DATA_IN = data_in;
  assign bus_u.DATA_WE = data_we; assign bus_b.DATA_WE = data_we; assign bus_t.DATA_WE = data_we;
  assign bus_u.SEED_WE = seed_we; assign bus_b.SEED_WE = seed_we; assign bus_t.SEED_WE = seed_we;
  assign bus_u.LEN_WE = len_we;   assign bus_b.LEN_WE = len_we;   assign bus_t.LEN_WE = len_we;

  sn_generate #(.MODE(2'd0), .WIDTH(W)) u_uni (.CLK(CLK), .RST_X(RST_X), .bus(bus_u.slave));
  sn_generate #(.MODE(2'd1), .WIDTH(W)) u_bip (.CLK(CLK), .RST_X(RST_X), .bus(bus_b.slave));
  sn_generate #(.MODE(2'd2), .WIDTH(W)) u_two (.CLK(CLK), .RST_X(RST_X), .bus(bus_t.slave));

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] t;
    t = s >> 1;
    if (s[0]) t = t ^ 32'h8020_0003;
    return t;
  endfunction

  function automatic longint sat_u(input logic [31:0] d);
    longint v;
    v = longint'(d);
    return (v > 65536) ? 65536 : v;
  endfunction

  function automatic longint sat_s(input logic [31:0] d);
    longint v;
    v = longint'(signed'(d));
    if (v > 65536) v = 65536;
    if (v < -65536) v = -65536;
    return v;
  endfunction

  task automatic model_reset();
    m_state = 32'h1234_5678;
    m_val_u = 0;
    m_val_s = 0;
    m_rem   = 0;
    {m_p_u, m_p_b, m_p_t, m_n_t} = 4'b0000;
`ifdef SN_LENGTH_EN
    m_done = 1'b1;
`else
    m_done = 1'b0;
`endif
  endtask

  task automatic model_edge();
    logic   run;
    longint r16, r17, mag;
    run = en;
`ifdef SN_LENGTH_EN
    run = en && (m_rem > 0);
`endif
    r16 = longint'(m_state[15:0]);
    r17 = longint'(m_state[16:0]);
    mag = (m_val_s < 0) ? -m_val_s : m_val_s;
    if (en) begin
      m_p_u = run && (r16 < m_val_u);
      m_p_b = run && (r17 < m_val_s + 65536);
      m_p_t = run && (m_val_s >= 0) && (r16 < mag);
      m_n_t = run && (m_val_s < 0) && (r16 < mag);
    end
    if (seed_we) m_state = (data_in == 32'd0) ? 32'd1 : data_in;
    else if (run) m_state = lfsr_next(m_state);
    if (data_we) begin
      m_val_u = sat_u(data_in);
      m_val_s = sat_s(data_in);
    end
`ifdef SN_LENGTH_EN
    if (len_we) m_rem = longint'(data_in);
    else if (run) m_rem = m_rem - 1;
    m_done = (m_rem == 0);
`endif
  endtask

  task automatic compare_all();
    check_bit("uni_p", bus_u.SN_OUT_P, m_p_u);
    check_bit("uni_n", bus_u.SN_OUT_N, 1'b0);
    check_bit("bip_p", bus_b.SN_OUT_P, m_p_b);
    check_bit("bip_n", bus_b.SN_OUT_N, 1'b0);
    check_bit("two_p", bus_t.SN_OUT_P, m_p_t);
    check_bit("two_n", bus_t.SN_OUT_N, m_n_t);
    check_output("uni_data_out", bus_u.DATA_OUT, m_val_u[31:0]);
    check_output("bip_data_out", bus_b.DATA_OUT, m_val_s[31:0]);
    check_output("two_data_out", bus_t.DATA_OUT, m_val_s[31:0]);
    check_bit("uni_done", bus_u.DONE, m_done);
    check_bit("bip_done", bus_b.DONE, m_done);
    check_bit("two_done", bus_t.DONE, m_done);
  endtask

  task automatic apply_stimulus(input logic e, input logic dwe, input logic swe,
                                input logic lwe, input logic [31:0] d);
    en = e; data_we = dwe; seed_we = swe; len_we = lwe; data_in = d;
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
    cnt_u    += {31'd0, bus_u.SN_OUT_P};
    cnt_b    += {31'd0, bus_b.SN_OUT_P};
    cnt_tp   += {31'd0, bus_t.SN_OUT_P};
    cnt_tn   += {31'd0, bus_t.SN_OUT_N};
    m_cnt_tn += {31'd0, m_n_t};
  endtask

  task automatic clear_counts();
    cnt_u = 0; cnt_b = 0; cnt_tp = 0; cnt_tn = 0; m_cnt_tn = 0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic pulse_reset();
    en = 1'b0; data_we = 1'b0; seed_we = 1'b0; len_we = 1'b0;
    #2;
    RST_X = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLK);
    RST_X = 1'b1;
  endtask

  // Length is ignored in the free-running build, so this is harmless there
  task automatic open_length();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
  endtask

  initial begin
    RST_X = 1'b0;
    en = 1'b0; data_we = 1'b0; seed_we = 1'b0; len_we = 1'b0; data_in = 32'd0;
    clear_counts();
    model_reset();
    #12;
    $display("[TB] reset values");
    compare_all();
    @(negedge CLK);
    RST_X = 1'b1;
    open_length();

    $display("[TB] hand-computed bits from seed 1234_5678");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd22136);
    check_output("hand_data_out", bus_u.DATA_OUT, 32'd22136);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("hand0_uni", bus_u.SN_OUT_P, 1'b0);
    check_bit("hand0_bip", bus_b.SN_OUT_P, 1'b1);
    check_bit("hand0_two", bus_t.SN_OUT_P, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("hand1_uni", bus_u.SN_OUT_P, 1'b1);
    check_bit("hand1_two", bus_t.SN_OUT_P, 1'b1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd5534);
    check_bit("val_collide_uni", bus_u.SN_OUT_P, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("hand3_uni", bus_u.SN_OUT_P, 1'b0);
    check_bit("hand3_bip", bus_b.SN_OUT_P, 1'b1);

    $display("[TB] seed handling");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd2);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("seed0_bit0", bus_u.SN_OUT_P, 1'b1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("seed0_bit1", bus_u.SN_OUT_P, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    check_bit("seed_collide_old", bus_u.SN_OUT_P, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("seed_collide_new", bus_u.SN_OUT_P, 1'b1);

    $display("[TB] saturation");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd70000);
    check_output("sat_uni_70000", bus_u.DATA_OUT, 32'd65536);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd65537);
    check_output("sat_bip_65537", bus_b.DATA_OUT, 32'd65536);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFE_7960);
    check_output("sat_bip_m100000", bus_b.DATA_OUT, 32'hFFFF_0000);
    check_output("sat_uni_big", bus_u.DATA_OUT, 32'd65536);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_0001);
    check_output("sat_bip_m65535", bus_b.DATA_OUT, 32'hFFFF_0001);

    $display("[TB] constant streams");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    clear_counts();
    run_cycles(1000);
    check_output("zero_uni_count", cnt_u, 32'd0);
    check_output("zero_two_count", cnt_tp + cnt_tn, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd65536);
    clear_counts();
    run_cycles(1000);
    check_output("full_uni_count", cnt_u, 32'd1000);
    check_output("full_bip_count", cnt_b, 32'd1000);
    check_output("full_two_count", cnt_tp, 32'd1000);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_0000);
    clear_counts();
    run_cycles(1000);
    check_output("neg_bip_count", cnt_b, 32'd0);
    check_output("neg_two_n_count", cnt_tn, 32'd1000);
    check_output("neg_two_p_count", cnt_tp, 32'd0);

    $display("[TB] statistical streams");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd16384);
    clear_counts();
    run_cycles(32768);
    check_bit("quarter_uni_ratio", (cnt_u >= 32'd7680) && (cnt_u <= 32'd8704), 1'b1);
    check_bit("quarter_bip_ratio", (cnt_b >= 32'd19968) && (cnt_b <= 32'd20992), 1'b1);
    check_bit("quarter_two_ratio", (cnt_tp >= 32'd7680) && (cnt_tp <= 32'd8704), 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    clear_counts();
    run_cycles(16384);
    check_bit("half_bip_ratio", (cnt_b >= 32'd8028) && (cnt_b <= 32'd8356), 1'b1);

    $display("[TB] two-line signs");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FED4);
    clear_counts();
    run_cycles(4096);
    check_output("m300_p_count", cnt_tp, 32'd0);
    check_output("m300_n_count", cnt_tn, m_cnt_tn);
    check_bit("m300_n_seen", cnt_tn > 32'd0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd300);
    clear_counts();
    run_cycles(4096);
    check_output("p300_n_count", cnt_tn, 32'd0);
    check_bit("p300_p_seen", cnt_tp > 32'd0, 1'b1);

    $display("[TB] reset mid-stream");
    pulse_reset();
    check_output("rst_data_out", bus_b.DATA_OUT, 32'd0);
    open_length();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd22136);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("rst_seed_bit0", bus_u.SN_OUT_P, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("rst_seed_bit1", bus_u.SN_OUT_P, 1'b1);

`ifdef SN_LENGTH_EN
    $display("[TB] length counter");
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
    check_bit("len_zero_done", bus_u.DONE, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd65536);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd10);
    check_bit("len_loaded_done", bus_u.DONE, 1'b0);
    clear_counts();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("len_done_after_10", bus_u.DONE, 1'b1);
    run_cycles(5);
    check_output("len_bits_emitted", cnt_u, 32'd10);
    check_bit("len_tail_zero", bus_u.SN_OUT_P, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd3);
    check_bit("len_collide_bit", bus_u.SN_OUT_P, 1'b0);
    check_bit("len_collide_done", bus_u.DONE, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    check_bit("len_reload_bit", bus_u.SN_OUT_P, 1'b1);
    pulse_reset();
    check_bit("len_rst_done", bus_u.DONE, 1'b1);
    check_bit("len_rst_out", bus_u.SN_OUT_P, 1'b0);
`else
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check_bit("free_done_low", bus_u.DONE, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
